bayer_to_rgb: RTL and testbench

Converts the raw 12-bit Bayer pixel stream from the camera capture path into RGB pixels for the colour-to-grayscale convolution stage. Each 2x2 GRBG quad becomes one RGB pixel, so an IMG_WIDTH x IMG_HEIGHT raw frame yields an (IMG_WIDTH/2) x (IMG_HEIGHT/2) RGB frame. Even raw rows are held in a one-line buffer and combined with odd rows as they arrive. The output drives the convolution stage's 12-bit red/green/blue/valid inputs directly.

---
 rtl/bayer_to_rgb.sv | 103 ++++++++++
 tb/tb_bayer_to_rgb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bayer_to_rgb.sv
// GRBG Bayer quad to RGB converter: one RGB pixel per 2x2 quad, 2-clock latency.
// Define BAYER_SWAP_RB_EN for GBRG sensors (red and blue sources exchanged).
module bayer_to_rgb #(
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 960
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_raw,
    input  logic        i_valid,
    input  logic        i_sof,
    output logic [11:0] o_red,
    output logic [11:0] o_green,
    output logic [11:0] o_blue,
    output logic        o_valid,
    output logic        o_frame_done
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

    logic [COL_W-1:0] col, eff_col;
    logic [ROW_W-1:0] row, eff_row;
    logic             last_col, last_row, odd_row, odd_col, px_out;

    logic [11:0] line_buf [IMG_WIDTH];
    logic [11:0] rd_data;
    logic [11:0] g1_q, g2_q, b_q;
    logic        g1_pend;
    logic [2:1]  vld_pipe;
    logic [2:1]  fd_pipe;
    logic [12:0] g_sum;

    // A start-of-frame pixel is treated as (0,0) in the same cycle it arrives.
    always_comb begin
        eff_col  = i_sof ? '0 : col;
        eff_row  = i_sof ? '0 : row;
        last_col = (eff_col == COL_W'(IMG_WIDTH - 1));
        last_row = (eff_row == ROW_W'(IMG_HEIGHT - 1));
        odd_row  = eff_row[0];
        odd_col  = eff_col[0];
        px_out   = i_valid && odd_row && odd_col;
        g_sum    = {1'b0, g1_q} + {1'b0, g2_q};
    end

    // Even rows fill the buffer; odd rows read it. One access per pixel, so a
    // single-port RAM suffices: G1 is fetched on the even column, R on the odd.
    always_ff @(posedge i_clk) begin
        if (i_valid && !odd_row)
            line_buf[eff_col] <= i_raw;
        if (i_valid && odd_row)
            rd_data <= line_buf[eff_col];
    end

    always_ff @(posedge i_clk) begin
        if (g1_pend)
            g1_q <= rd_data;
        if (i_valid && odd_row && !odd_col)
            b_q <= i_raw;
        if (px_out)
            g2_q <= i_raw;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col      <= '0;
            row      <= '0;
            g1_pend  <= 1'b0;
            vld_pipe <= '0;
            fd_pipe  <= '0;
            o_red    <= '0;
            o_green  <= '0;
            o_blue   <= '0;
        end else begin
            if (i_valid) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : eff_row + 1'b1;
                end else begin
                    col <= eff_col + 1'b1;
                    row <= eff_row;
                end
            end
            g1_pend     <= i_valid && odd_row && !odd_col;
            vld_pipe[1] <= px_out;
            fd_pipe[1]  <= px_out && last_row && last_col;
            vld_pipe[2] <= vld_pipe[1];
            fd_pipe[2]  <= fd_pipe[1];
            if (vld_pipe[1]) begin
                o_green <= g_sum[12:1];
`ifdef BAYER_SWAP_RB_EN
                o_red   <= b_q;
                o_blue  <= rd_data;
`else
                o_red   <= rd_data;
                o_blue  <= b_q;
`endif
            end
        end
    end

    assign o_valid      = vld_pipe[2];
    assign o_frame_done = fd_pipe[2];
endmodule

// File: tb/tb_bayer_to_rgb.sv
// Self-checking bench for bayer_to_rgb: directed table, sof/reset sequences,
// and randomized gapped traffic against a frame-array reference model.
module tb_bayer_to_rgb;
    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst, valid, sof;
    logic [11:0] raw;
    logic [11:0] o_red, o_green, o_blue;
    logic        o_valid, o_frame_done;

    always #5 clk = ~clk;

    bayer_to_rgb #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk(clk), .i_rst(rst), .i_raw(raw), .i_valid(valid), .i_sof(sof),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_valid(o_valid), .o_frame_done(o_frame_done)
    );

    typedef struct { int cyc; int r; int g; int b; int fd; } exp_t;
    typedef struct { int r; int g; int b; int fd; } obs_t;
    typedef struct { int px[8]; bit gap; int r0, g0, b0, r1, g1, b1; } vec_t;

    exp_t expq[$];
    obs_t obsq[$];
    int   img[H][W];
    int   mr, mc, cyc;
    int   n_chk, n_pass;
    int   last_r, last_g, last_b;
    vec_t tbl[3];

    task automatic chk(string name, int act, int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (step %0d)", name, act, want, cyc);
    endtask

    // Reference: keep the whole frame, form each quad straight from its rows.
    task automatic model_px(bit s, int px);
        exp_t e;
        if (s) begin mr = 0; mc = 0; end
        img[mr][mc] = px;
        if (mr % 2 == 1 && mc % 2 == 1) begin
            e.cyc = cyc + 2;
            e.g   = (img[mr-1][mc-1] + px) / 2;
            e.fd  = (mr == H-1 && mc == W-1) ? 1 : 0;
`ifdef BAYER_SWAP_RB_EN
            e.r = img[mr][mc-1];
            e.b = img[mr-1][mc];
`else
            e.r = img[mr-1][mc];
            e.b = img[mr][mc-1];
`endif
            expq.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end
    endtask

    task automatic monitor();
        exp_t e;
        obs_t o;
        bit   want;
        want = (expq.size() > 0) && (expq[0].cyc == cyc);
        chk("o_valid", int'(o_valid), int'(want));
        if (want) begin
            e = expq.pop_front();
            chk("red", int'(o_red), e.r);
            chk("green", int'(o_green), e.g);
            chk("blue", int'(o_blue), e.b);
            chk("frame_done", int'(o_frame_done), e.fd);
            last_r = e.r; last_g = e.g; last_b = e.b;
        end else begin
            chk("hold_red", int'(o_red), last_r);
            chk("hold_green", int'(o_green), last_g);
            chk("hold_blue", int'(o_blue), last_b);
            chk("frame_done_idle", int'(o_frame_done), 0);
        end
        if (o_valid) begin
            o.r = o_red; o.g = o_green; o.b = o_blue; o.fd = o_frame_done;
            obsq.push_back(o);
        end
    endtask

    task automatic step(bit r_, bit v, bit s, int px);
        @(posedge clk);
        #1;
        rst = r_; valid = v; sof = s; raw = px[11:0];
        if (!r_ && v) model_px(s, px);
        @(negedge clk);
        monitor();
        if (r_) begin
            while (expq.size() > 0 && expq[$].cyc >= cyc + 1) void'(expq.pop_back());
            mr = 0; mc = 0;
            last_r = 0; last_g = 0; last_b = 0;
        end
        cyc++;
    endtask

    // Expected values are written in GRBG terms; swap builds exchange R and B.
    task automatic chk_obs(string tag, int idx, int r, int g, int b, int fd);
        obs_t o;
        if (idx >= obsq.size()) begin
            chk({tag, "_present"}, obsq.size(), idx + 1);
            return;
        end
        o = obsq[idx];
`ifdef BAYER_SWAP_RB_EN
        chk({tag, "_red"}, o.r, b);
        chk({tag, "_blue"}, o.b, r);
`else
        chk({tag, "_red"}, o.r, r);
        chk({tag, "_blue"}, o.b, b);
`endif
        chk({tag, "_green"}, o.g, g);
        chk({tag, "_fd"}, o.fd, fd);
    endtask

    int sof_px[14];
    int v;

    initial begin
        tbl[0].px = '{100, 200, 102, 300, 50, 104, 60, 106}; tbl[0].gap = 1'b0;
        tbl[0].r0 = 200; tbl[0].g0 = 102; tbl[0].b0 = 50;
        tbl[0].r1 = 300; tbl[0].g1 = 104; tbl[0].b1 = 60;
        tbl[1] = tbl[0]; tbl[1].gap = 1'b1;
        tbl[2].px = '{4095, 7, 1, 9, 11, 4094, 13, 0}; tbl[2].gap = 1'b0;
        tbl[2].r0 = 7; tbl[2].g0 = 4094; tbl[2].b0 = 11;
        tbl[2].r1 = 9; tbl[2].g1 = 0;    tbl[2].b1 = 13;

        n_chk = 0; n_pass = 0; cyc = 0; mr = 0; mc = 0;
        last_r = 0; last_g = 0; last_b = 0;
        rst = 1'b1; valid = 1'b0; sof = 1'b0; raw = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_fd", int'(o_frame_done), 0);
        chk("reset_red", int'(o_red), 0);
        chk("reset_green", int'(o_green), 0);
        chk("reset_blue", int'(o_blue), 0);

        // Directed table: continuous, gapped, and green rounding extremes.
        for (int t = 0; t < 3; t++) begin
            obsq.delete();
            for (int k = 0; k < 8; k++) begin
                step(0, 1, k == 0, tbl[t].px[k]);
                if (tbl[t].gap) step(0, 0, 0, 0);
            end
            repeat (3) step(0, 0, 0, 0);
            chk($sformatf("tbl%0d_count", t), obsq.size(), 2);
            chk_obs($sformatf("tbl%0d_p0", t), 0, tbl[t].r0, tbl[t].g0, tbl[t].b0, 0);
            chk_obs($sformatf("tbl%0d_p1", t), 1, tbl[t].r1, tbl[t].g1, tbl[t].b1, 1);
        end

        // Restart at raw (1,2): the (1,1) result survives, then a fresh frame.
        sof_px = '{100, 200, 102, 300, 50, 104, 10, 20, 30, 40, 5, 6, 7, 8};
        obsq.delete();
        for (int k = 0; k < 14; k++) step(0, 1, (k == 0) || (k == 6), sof_px[k]);
        repeat (3) step(0, 0, 0, 0);
        chk("sof_count", obsq.size(), 3);
        chk_obs("sof_old", 0, 200, 102, 50, 0);
        chk_obs("sof_new0", 1, 20, 8, 5, 0);
        chk_obs("sof_new1", 2, 40, 19, 7, 1);

        // Reset one cycle after (1,1): that result must never emerge.
        obsq.delete();
        for (int k = 0; k < 6; k++) step(0, 1, k == 0, tbl[0].px[k]);
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        chk("rst_count", obsq.size(), 0);
        chk("rst_red", int'(o_red), 0);
        chk("rst_green", int'(o_green), 0);
        chk("rst_blue", int'(o_blue), 0);

        // Random gapped traffic with occasional mid-frame restarts.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0);
            else begin
                if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) == 1) ? 4095 : 0;
                else v = int'($urandom_range(0, 4095));
                step(0, 1, (k == 0) || ($urandom_range(0, 49) == 0), v);
            end
        end
        repeat (4) step(0, 0, 0, 0);
        chk("drain_pending", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
